// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared types and sizing helpers for the sequential restoring divider.
//   - state_t     : controller states (IDLE, RUN, ZERO)
//   - BITS_DEFAULT: default operand width
//   - CNT_W       : step-counter width for the default operand width
//   - cnt_width() : step-counter width for any operand width
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  localparam int BITS_DEFAULT = 32;
  localparam int CNT_W        = $clog2(BITS_DEFAULT) + 1;

  // Counter width for an arbitrary operand width. The counter only has to
  // reach BITS-1, so $clog2(bits)+1 leaves one bit of headroom.
  function automatic int cnt_width(input int bits);
    return $clog2(bits) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   Ports:
//     r       in   BITS  partial remainder (always < divisor, so BITS bits hold it)
//     q       in   BITS  working quotient / remaining dividend bits
//     divisor in   BITS  denominator
//     r_next  out  BITS  partial remainder after this step
//     q_next  out  BITS  working quotient after this step
//   The trial remainder is formed BITS+1 bits wide; the MSB of the BITS+1 bit
//   subtraction is the borrow, which decides restore vs. keep.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] r,
  input  logic [BITS-1:0] q,
  input  logic [BITS-1:0] divisor,
  output logic [BITS-1:0] r_next,
  output logic [BITS-1:0] q_next
);

  logic [BITS:0] shifted;
  logic [BITS:0] diff;
  logic          borrow;

  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch
    // can be inferred.
    shifted = {r, q[BITS-1]};
    diff    = shifted - {1'b0, divisor};
    borrow  = diff[BITS];
    // Borrow set means shifted < divisor: restore (keep shifted), quotient bit 0.
    r_next  = borrow ? shifted[BITS-1:0] : diff[BITS-1:0];
    q_next  = {q[BITS-2:0], ~borrow};
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider for the ALU DIV path. One quotient bit per
//   clock; BITS steps after the accepting edge the result is registered and
//   done pulses for one cycle. Quotient feeds LO, remainder feeds HI.
//   Ports:
//     clock        in   1     system clock, rising edge
//     clear_n      in   1     asynchronous reset, active-low
//     start        in   1     request a divide; only honoured while busy=0
//     dividend     in   BITS  numerator, captured on the accepting edge
//     divisor      in   BITS  denominator, captured on the accepting edge
//     busy         out  1     high while a divide is in progress
//     done         out  1     one-cycle pulse, results valid
//     quotient     out  BITS  held until the next divide completes
//     remainder    out  BITS  held until the next divide completes
//     div_by_zero  out  1     set with done when divisor==0, held with results
//   Configuration macro:
//     SEQ_DIVIDER_SIGNED_EN  defined: two's-complement operands (magnitude
//                            division with a combinational sign fix-up on the
//                            final step). Undefined: unsigned only.
//   Divide by zero takes one cycle: quotient all ones, remainder = dividend.
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(BITS);
  localparam logic [CW-1:0] LAST_STEP = CW'(BITS - 1);

  state_t          state;
  logic [BITS-1:0] r_acc;   // partial remainder; never reaches divisor
  logic [BITS-1:0] q_acc;   // shifts dividend bits out, quotient bits in
  logic [BITS-1:0] dvsr;
  logic [CW-1:0]   count;

  logic [BITS-1:0] r_nxt;
  logic [BITS-1:0] q_nxt;

  // Operand magnitudes at acceptance and sign-corrected results.
  logic [BITS-1:0] a_mag;
  logic [BITS-1:0] b_mag;
  logic [BITS-1:0] q_fix;
  logic [BITS-1:0] r_fix;
  logic [BITS-1:0] z_rem;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg;   // operand signs differ
  logic r_neg;   // dividend negative
`endif

  div_step #(
    .BITS(BITS)
  ) u_step (
    .r      (r_acc),
    .q      (q_acc),
    .divisor(dvsr),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fix = q_nxt;
    r_fix = r_nxt;
    // In ZERO no steps have run, so q_acc still holds the dividend magnitude.
    z_rem = q_acc;
`ifdef SEQ_DIVIDER_SIGNED_EN
    // Most-negative stays 100..0, which read unsigned is the correct magnitude.
    if (dividend[BITS-1]) a_mag = {BITS{1'b0}} - dividend;
    if (divisor[BITS-1])  b_mag = {BITS{1'b0}} - divisor;
    if (q_neg)            q_fix = {BITS{1'b0}} - q_nxt;
    if (r_neg) begin
      r_fix = {BITS{1'b0}} - r_nxt;
      z_rem = {BITS{1'b0}} - q_acc;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      r_acc       <= '0;
      q_acc       <= '0;
      dvsr        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q_acc <= a_mag;
            dvsr  <= b_mag;
            r_acc <= '0;
            count <= '0;
            busy  <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg <= dividend[BITS-1] ^ divisor[BITS-1];
            r_neg <= dividend[BITS-1];
`endif
            state <= (divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          r_acc <= r_nxt;
          q_acc <= q_nxt;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        ZERO: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          quotient    <= '1;
          remainder   <= z_rem;
          div_by_zero <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
